collision_monitor: RTL and testbench

- Sequential, parametrised successor to the combinational per-pixel collision counter.
- Per pixel: counts active layer enables, registers the count and a collision flag.
- Per frame: accumulates collision statistics and hands a frame report to the control/readout logic over a valid/ready handshake.
- Sits after the per-layer pixel generators, in parallel with the pixel mixer.

---
 rtl/collision_monitor_pkg.sv | 18 +
 rtl/collision_monitor_popcount.sv | 19 +
 rtl/collision_monitor.sv | 144 ++++++++++++++
 tb/tb_collision_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_monitor_pkg.sv
// Shared types and helpers for the collision monitor and the pixel mixer.
package gpu_collision_pkg;

   localparam int DEF_WIDTH       = 4;
   localparam int DEF_FRAME_CNT_W = 20;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      REPORT = 2'd2
   } state_t;

   // Bits needed to hold a count of 0..w active enables.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/collision_monitor_popcount.sv
// Combinational population count of the layer enable vector.
module collision_popcount
   import gpu_collision_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int CW    = cnt_width(WIDTH)
) (
   input  logic [WIDTH-1:0] enable,
   output logic [CW-1:0]    count
);

   // Sum the enable bits.
   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++)
         count = count + CW'(enable[i]);
   end

endmodule

// File: rtl/collision_monitor.sv
// Per-pixel collision flagging plus per-frame statistics with a
// valid/ready frame report.
module collision_monitor
   import gpu_collision_pkg::*;
#(
   parameter  int WIDTH       = DEF_WIDTH,
   parameter  int FRAME_CNT_W = DEF_FRAME_CNT_W,
   parameter  int COLL_MIN    = 2,
   localparam int CW          = cnt_width(WIDTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       enable,
   input  logic                   pixel_valid,
   input  logic                   frame_start,
   input  logic                   frame_end,
   input  logic [FRAME_CNT_W-1:0] threshold,
   output logic [CW-1:0]          pixel_count,
   output logic                   pixel_collision,
   output logic [FRAME_CNT_W-1:0] frame_collisions,
   output logic [CW-1:0]          frame_max,
   output logic [WIDTH-1:0]       frame_first_mask,
   output logic                   report_valid,
   input  logic                   report_ready,
   output logic                   threshold_hit,
   output logic                   overrun
);

   localparam logic [CW-1:0] COLL_MIN_C = CW'(COLL_MIN);

   state_t                 state;
   logic [CW-1:0]          pop;
   logic                   coll_now;
   logic                   upd;
   logic [FRAME_CNT_W-1:0] acc, acc_post, acc_n;
   logic [CW-1:0]          max_r, max_n;
   logic [WIDTH-1:0]       mask_r, mask_n;
   logic                   hit_done;
   logic                   thr_cross;

   collision_popcount #(.WIDTH(WIDTH)) u_pop (
      .enable (enable),
      .count  (pop)
   );

   // Next accumulator values if the current pixel is folded into the frame.
   // acc only grows within a frame, so acc==0 marks "no collision yet".
   always_comb begin
      coll_now  = (pop >= COLL_MIN_C);
      upd       = pixel_valid && coll_now;
      acc_post  = (acc == '1) ? acc : acc + 1'b1;
      acc_n     = upd ? acc_post : acc;
      max_n     = (pixel_valid && (pop > max_r)) ? pop : max_r;
      mask_n    = (upd && (acc == '0)) ? enable : mask_r;
      thr_cross = (threshold != '0) && (acc < threshold) &&
                  (acc_post >= threshold) && !hit_done;
   end

   // Frame FSM with accumulators, report registers and event pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         acc              <= '0;
         max_r            <= '0;
         mask_r           <= '0;
         hit_done         <= 1'b0;
         pixel_count      <= '0;
         pixel_collision  <= 1'b0;
         frame_collisions <= '0;
         frame_max        <= '0;
         frame_first_mask <= '0;
         report_valid     <= 1'b0;
         threshold_hit    <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         threshold_hit <= 1'b0;
         overrun       <= 1'b0;
         if (pixel_valid) begin
            pixel_count     <= pop;
            pixel_collision <= coll_now;
         end
         case (state)
            IDLE: begin
               if (frame_start) begin
                  acc      <= '0;
                  max_r    <= '0;
                  mask_r   <= '0;
                  hit_done <= 1'b0;
                  if (frame_end) begin
                     // Empty frame: report straight from cleared values.
                     frame_collisions <= '0;
                     frame_max        <= '0;
                     frame_first_mask <= '0;
                     report_valid     <= 1'b1;
                     state            <= REPORT;
                  end else begin
                     state <= ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               if (frame_start) begin
                  acc      <= '0;
                  max_r    <= '0;
                  mask_r   <= '0;
                  hit_done <= 1'b0;
               end else begin
                  acc    <= acc_n;
                  max_r  <= max_n;
                  mask_r <= mask_n;
                  if (upd && thr_cross) begin
                     threshold_hit <= 1'b1;
                     hit_done      <= 1'b1;
                  end
                  if (frame_end) begin
                     frame_collisions <= acc_n;
                     frame_max        <= max_n;
                     frame_first_mask <= mask_n;
                     report_valid     <= 1'b1;
                     state            <= REPORT;
                  end
               end
            end
            REPORT: begin
               if (report_ready || frame_start) begin
                  report_valid <= 1'b0;
                  overrun      <= frame_start && !report_ready;
                  if (frame_start) begin
                     acc      <= '0;
                     max_r    <= '0;
                     mask_r   <= '0;
                     hit_done <= 1'b0;
                     state    <= ACTIVE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_monitor.sv
// Randomized scoreboard bench for collision_monitor (WIDTH=4, FRAME_CNT_W=3).
module tb_collision_monitor;

   localparam int W   = 4;
   localparam int FW  = 3;
   localparam int CM  = 2;
   localparam int CW  = 3;
   localparam int SAT = 7;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  enable = '0;
   logic          pixel_valid = 1'b0;
   logic          frame_start = 1'b0;
   logic          frame_end = 1'b0;
   logic [FW-1:0] threshold = '0;
   logic          report_ready = 1'b0;
   logic [CW-1:0] pixel_count;
   logic          pixel_collision;
   logic [FW-1:0] frame_collisions;
   logic [CW-1:0] frame_max;
   logic [W-1:0]  frame_first_mask;
   logic          report_valid;
   logic          threshold_hit;
   logic          overrun;

   collision_monitor #(.WIDTH(W), .FRAME_CNT_W(FW), .COLL_MIN(CM)) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .pixel_valid      (pixel_valid),
      .frame_start      (frame_start),
      .frame_end        (frame_end),
      .threshold        (threshold),
      .pixel_count      (pixel_count),
      .pixel_collision  (pixel_collision),
      .frame_collisions (frame_collisions),
      .frame_max        (frame_max),
      .frame_first_mask (frame_first_mask),
      .report_valid     (report_valid),
      .report_ready     (report_ready),
      .threshold_hit    (threshold_hit),
      .overrun          (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int coll;
      int mx;
      int mask;
   } rep_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   pv_d;
   rep_t rep_q[$];
   int   pix_q[$];
   int   hit_q[$];
   int   ovr_q[$];

   // Reference model state: one frame in progress, one report outstanding.
   bit   m_act, m_pend;
   int   m_coll, m_max, m_mask;

   int   mon_e;
   bit   mon_x;
   rep_t mon_r;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycle counter and pixel-valid delay used by the monitor.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      pv_d <= pixel_valid && !reset;
   end

   // Monitor: pops expectations whenever the DUT presents an output.
   always @(negedge clk) begin
      if (!reset) begin
         if (pv_d) begin
            if (pix_q.size() == 0) chk("pixel_unexpected", 1, 0);
            else begin
               mon_e = pix_q.pop_front();
               chk("pixel_count", int'(pixel_count), mon_e);
               chk("pixel_collision", int'(pixel_collision), int'(mon_e >= CM));
            end
         end
         if (report_valid && report_ready) begin
            if (rep_q.size() == 0) chk("report_unexpected", 1, 0);
            else begin
               mon_r = rep_q.pop_front();
               chk("frame_collisions", int'(frame_collisions), mon_r.coll);
               chk("frame_max", int'(frame_max), mon_r.mx);
               chk("frame_first_mask", int'(frame_first_mask), mon_r.mask);
            end
         end
         mon_x = (hit_q.size() > 0) && (hit_q[0] == cyc);
         if (mon_x) void'(hit_q.pop_front());
         if (mon_x || threshold_hit) chk("threshold_hit", int'(threshold_hit), int'(mon_x));
         mon_x = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
         if (mon_x) void'(ovr_q.pop_front());
         if (mon_x || overrun) chk("overrun", int'(overrun), int'(mon_x));
      end
   end

   // Drive one cycle of stimulus and advance the frame-level model.
   task automatic step(input bit fs, input bit fe, input bit pv,
                       input logic [W-1:0] en, input bit rdy);
      int   pc;
      rep_t r;
      frame_start  = fs;
      frame_end    = fe;
      pixel_valid  = pv;
      enable       = en;
      report_ready = rdy;
      pc = $countones(en);
      if (pv) pix_q.push_back(pc);
      if (m_pend) begin
         if (rdy) m_pend = 1'b0;
         else if (fs) begin
            ovr_q.push_back(cyc + 1);
            void'(rep_q.pop_back());
            m_pend = 1'b0;
         end
      end
      if (fs) begin
         m_act = 1'b1; m_coll = 0; m_max = 0; m_mask = 0;
         if (fe) begin
            r.coll = 0; r.mx = 0; r.mask = 0;
            rep_q.push_back(r);
            m_act = 1'b0; m_pend = 1'b1;
         end
      end else if (m_act) begin
         if (pv) begin
            if (pc > m_max) m_max = pc;
            if (pc >= CM) begin
               if (m_coll == 0) m_mask = int'(en);
               m_coll++;
               if (threshold != 0 && m_coll == int'(threshold)) hit_q.push_back(cyc + 1);
            end
         end
         if (fe) begin
            r.coll = (m_coll > SAT) ? SAT : m_coll;
            r.mx   = m_max;
            r.mask = m_mask;
            rep_q.push_back(r);
            m_act = 1'b0; m_pend = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      frame_start = 1'b0; frame_end = 1'b0; pixel_valid = 1'b0; report_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      rep_q.delete(); pix_q.delete(); hit_q.delete(); ovr_q.delete();
      m_act = 1'b0; m_pend = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pixel_count"}, int'(pixel_count), 0);
      chk({tag, "_pixel_collision"}, int'(pixel_collision), 0);
      chk({tag, "_frame_collisions"}, int'(frame_collisions), 0);
      chk({tag, "_frame_max"}, int'(frame_max), 0);
      chk({tag, "_frame_first_mask"}, int'(frame_first_mask), 0);
      chk({tag, "_report_valid"}, int'(report_valid), 0);
      chk({tag, "_threshold_hit"}, int'(threshold_hit), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      int n;
      do_reset();
      check_zero("reset");

      // Basic frame with threshold 2: hit follows pixel 0111.
      threshold = 3'd2;
      step(1, 0, 0, 4'b0000, 0);
      step(0, 0, 1, 4'b0011, 0);
      step(0, 0, 1, 4'b0111, 0);
      step(0, 0, 1, 4'b0001, 0);
      step(0, 1, 1, 4'b1111, 0);
      step(0, 0, 0, 4'b0000, 0);
      step(0, 0, 0, 4'b0000, 0);
      chk("report_held", int'(report_valid), 1);
      chk("held_collisions", int'(frame_collisions), 3);
      chk("held_max", int'(frame_max), 4);
      chk("held_mask", int'(frame_first_mask), 4'b0011);
      step(0, 0, 0, 4'b0000, 1);
      step(0, 0, 0, 4'b0000, 0);
      chk("report_dropped", int'(report_valid), 0);

      // Saturation at 7 with threshold 7.
      threshold = 3'd7;
      step(1, 0, 0, 4'b0000, 0);
      repeat (9) step(0, 0, 1, 4'b1111, 0);
      step(0, 1, 1, 4'b1111, 0);

      // Overrun: frame_start with the report unread.
      step(1, 0, 0, 4'b0000, 0);
      chk("overrun_report_valid", int'(report_valid), 0);
      step(0, 0, 1, 4'b0011, 0);
      step(0, 1, 1, 4'b0101, 0);
      // frame_start together with report_ready: accepted, no overrun.
      step(1, 0, 1, 4'b0110, 1);
      step(0, 0, 1, 4'b1110, 0);
      step(0, 1, 1, 4'b1000, 0);
      step(0, 0, 0, 4'b0000, 1);
      step(0, 0, 0, 4'b0000, 1);

      // Empty frame from IDLE.
      step(1, 1, 0, 4'b0000, 0);
      step(0, 0, 0, 4'b0000, 1);
      step(0, 0, 0, 4'b0000, 0);

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         threshold = 3'($urandom_range(0, 7));
         if (!m_pend && $urandom_range(0, 7) == 0) begin
            step(1, 1, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
         end else begin
            step(1, 0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++)
               step($urandom_range(0, 14) == 0, 0, $urandom_range(0, 9) < 7,
                    4'($urandom), 1'($urandom_range(0, 1)));
            step(0, 1, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
         end
         repeat ($urandom_range(0, 3))
            step(0, 0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      end
      repeat (4) step(0, 0, 0, 4'b0000, 1);
      chk("reports_drained", rep_q.size(), 0);
      chk("hits_drained", hit_q.size(), 0);
      chk("overruns_drained", ovr_q.size(), 0);
      chk("pixels_drained", pix_q.size(), 0);

      // Reset in the middle of a frame after two collisions.
      threshold = 3'd0;
      step(1, 0, 0, 4'b0000, 0);
      step(0, 0, 1, 4'b1111, 0);
      step(0, 0, 1, 4'b0110, 0);
      do_reset();
      check_zero("midreset");
      step(0, 1, 0, 4'b0000, 1);
      repeat (3) begin
         step(0, 0, 0, 4'b0000, 1);
         chk("no_report_after_reset", int'(report_valid), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
